result_dump_ctrl: RTL and testbench
===================================

RESULT_DUMP_CTRL -- requirements
Module: result_dump_ctrl

Interface
REQ-001 Parameter DEPTH, default 8192, number of output-memory words drained per dump.
REQ-002 Parameter AW, default 13, address width; DEPTH SHALL be <= 2^AW.
REQ-003 clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Finish  in  1  completion flag from the Bellman-Ford engine.
REQ-006 NegCycle  in  1  negative-cycle flag from the Bellman-Ford engine.
REQ-007 OMAR  out  AW  read address to output memory, which has a combinational read port.
REQ-008 OMDR  in  16  read data from output memory, valid in the same cycle as OMAR.
REQ-009 DumpData  out  16  registered result word.
REQ-010 DumpInf  out  1  high when DumpData == 16'hFFFF (unreachable vertex).
REQ-011 DumpValid  out  1  DumpData is valid.
REQ-012 DumpReady  in  1  consumer accepts the word.
REQ-013 DumpLast  out  1  high with DumpValid on word DEPTH-1.
REQ-014 Busy  out  1  dump in progress (FETCH or SEND).
REQ-015 Done  out  1  sequence complete; sticky until reset.
REQ-016 NegFlag  out  1  dump suppressed because a negative cycle was reported; sticky until reset.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, SEND, NEG and DONE.
REQ-018 The block SHALL register Finish and NegCycle into Finish_q and Neg_q each cycle, and SHALL act only on rising edges: signal high while its _q is low.
REQ-019 In IDLE, a NegCycle rising edge SHALL move to NEG; this takes priority over a simultaneous Finish rising edge.
REQ-020 In IDLE, a Finish rising edge with no NegCycle rising edge SHALL set OMAR=0 and move to FETCH.
REQ-021 FETCH SHALL last exactly one cycle: capture OMDR into DumpData, set DumpInf = (OMDR == 16'hFFFF), set DumpValid=1, set DumpLast = (OMAR == DEPTH-1), then move to SEND.
REQ-022 In SEND, DumpData, DumpInf, DumpLast and DumpValid SHALL stay stable until the cycle in which DumpReady=1 (handshake).
REQ-023 On a SEND handshake with OMAR < DEPTH-1, the block SHALL increment OMAR by 1, clear DumpValid and move to FETCH.
REQ-024 On a SEND handshake with OMAR == DEPTH-1, the block SHALL clear DumpValid and DumpLast, hold OMAR, set Done and move to DONE.
REQ-025 Throughput SHALL be one word per two cycles when DumpReady is held high.
REQ-026 Each word SHALL be delivered exactly once; no duplicates and no skips.
REQ-027 OMAR SHALL never exceed DEPTH-1; there is no wrap-around.
REQ-028 NEG SHALL set NegFlag=1 and Done=1 on entry, and SHALL never assert DumpValid.
REQ-029 NEG and DONE SHALL be terminal until reset; all later Finish and NegCycle edges SHALL be ignored.
REQ-030 Edges of Finish or NegCycle during FETCH or SEND SHALL be ignored, and the dump SHALL complete.
REQ-031 Busy SHALL be 1 exactly when the state is FETCH or SEND.
REQ-032 DumpReady SHALL be ignored in every state other than SEND.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-dump.
REQ-034 On reset, OMAR, DumpData, DumpInf, DumpValid, DumpLast, Busy, Done and NegFlag SHALL all be 0.
REQ-035 On reset, Finish_q and Neg_q SHALL be set to 1, so a flag still high after reset release does not start a sequence; only a fresh 0->1 transition does.

Verification (DEPTH=4 override; memory preloaded {5, FFFF, 0, 12})
REQ-036 Finish 0->1, DumpReady=1 -> words 5, FFFF (DumpInf=1), 0, 12 on successive handshakes 2 cycles apart; DumpLast only on 12; Done=1 one cycle after the last handshake.
REQ-037 DumpReady low for 3 cycles on word 1 -> DumpData=FFFF and DumpValid held stable; OMAR=1 throughout; resumes on DumpReady=1 with no loss or duplication.
REQ-038 NegCycle and Finish rise in the same cycle from IDLE -> NEG; NegFlag=1, Done=1, DumpValid never asserted, OMAR stays 0.
REQ-039 reset asserted in SEND of word 2 while Finish stays high -> all outputs 0, IDLE; no restart until Finish drops and rises again, then full dump from address 0.
REQ-040 NegCycle rises during the dump, then Finish re-pulses after DONE -> dump completes normally with NegFlag=0; Done stays 1; no second dump.

Source files
------------

// File: rtl/result_dump_ctrl.sv
// result_dump_ctrl: drains DEPTH output-memory words over a valid/ready stream after Finish, or flags a negative cycle.
module result_dump_ctrl #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          Finish,
  input  logic          NegCycle,
  output logic [AW-1:0] OMAR,
  input  logic [15:0]   OMDR,
  output logic [15:0]   DumpData,
  output logic          DumpInf,
  output logic          DumpValid,
  input  logic          DumpReady,
  output logic          DumpLast,
  output logic          Busy,
  output logic          Done,
  output logic          NegFlag
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, FETCH, SEND, NEG, DONE} state_t;
  state_t state, state_n;
  logic finish_q, neg_q;
  logic [AW-1:0] omar_n;
  logic [15:0] data_n;
  logic inf_n, valid_n, last_n, done_n, negflag_n;
  logic fin_rise, neg_rise;
  assign fin_rise = Finish & ~finish_q;
  assign neg_rise = NegCycle & ~neg_q;
  assign Busy = (state == FETCH) || (state == SEND);
  always_comb begin
    state_n   = state;
    omar_n    = OMAR;
    data_n    = DumpData;
    inf_n     = DumpInf;
    valid_n   = DumpValid;
    last_n    = DumpLast;
    done_n    = Done;
    negflag_n = NegFlag;
    case (state)
      IDLE: begin
        if (neg_rise) begin
          state_n   = NEG;
          negflag_n = 1'b1;
          done_n    = 1'b1;
        end else if (fin_rise) begin
          state_n = FETCH;
          omar_n  = '0;
        end
      end
      FETCH: begin
        data_n  = OMDR;
        inf_n   = &OMDR;
        valid_n = 1'b1;
        last_n  = OMAR == LAST;
        state_n = SEND;
      end
      SEND: begin
        if (DumpReady) begin
          valid_n = 1'b0;
          if (OMAR == LAST) begin
            last_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            omar_n  = OMAR + AW'(1);
            state_n = FETCH;
          end
        end
      end
      default: ;
    endcase
  end
  // flag history resets high so a level held across reset is not an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      finish_q  <= 1'b1;
      neg_q     <= 1'b1;
      OMAR      <= '0;
      DumpData  <= '0;
      DumpInf   <= 1'b0;
      DumpValid <= 1'b0;
      DumpLast  <= 1'b0;
      Done      <= 1'b0;
      NegFlag   <= 1'b0;
    end else begin
      state     <= state_n;
      finish_q  <= Finish;
      neg_q     <= NegCycle;
      OMAR      <= omar_n;
      DumpData  <= data_n;
      DumpInf   <= inf_n;
      DumpValid <= valid_n;
      DumpLast  <= last_n;
      Done      <= done_n;
      NegFlag   <= negflag_n;
    end
  end
endmodule

// File: tb/tb_result_dump_ctrl.sv
// tb_result_dump_ctrl: directed scenarios with random data/ready checked against an expected word sequence.
module tb_result_dump_ctrl;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  logic clock = 0, reset, Finish, NegCycle, DumpReady;
  logic [AW-1:0] OMAR;
  logic [15:0] OMDR, DumpData;
  logic DumpInf, DumpValid, DumpLast, Busy, Done, NegFlag;
  logic [15:0] mem [DEPTH];
  int total = 0, bad = 0;
  assign OMDR = mem[OMAR];
  always #5 clock = ~clock;
  result_dump_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .Finish(Finish), .NegCycle(NegCycle),
    .OMAR(OMAR), .OMDR(OMDR), .DumpData(DumpData), .DumpInf(DumpInf),
    .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpLast(DumpLast),
    .Busy(Busy), .Done(Done), .NegFlag(NegFlag));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_omar"}, 32'(OMAR), 0);
    chk({tag, "_data"}, 32'(DumpData), 0);
    chk({tag, "_inf"}, 32'(DumpInf), 0);
    chk({tag, "_valid"}, 32'(DumpValid), 0);
    chk({tag, "_last"}, 32'(DumpLast), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_neg"}, 32'(NegFlag), 0);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask
  task automatic run_dump(input bit always_rdy, input bit noisy, input int abort);
    int idx = 0;
    bit hold = 0;
    logic [15:0] hold_data = 0;
    bit fin = 0;
    @(negedge clock);
    Finish = 0; NegCycle = 0; DumpReady = 0;
    @(negedge clock);
    Finish = 1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clock);
      chk("busy", 32'(Busy), 32'(idx < DEPTH));
      chk("omar", 32'(OMAR), 32'(idx < DEPTH ? idx : DEPTH - 1));
      chk("done", 32'(Done), 32'(idx == DEPTH));
      chk("negflag", 32'(NegFlag), 0);
      if (hold) begin
        chk("hold_valid", 32'(DumpValid), 1);
        chk("hold_data", 32'(DumpData), 32'(hold_data));
      end
      if (idx == DEPTH) begin
        chk("end_valid", 32'(DumpValid), 0);
        chk("end_last", 32'(DumpLast), 0);
        fin = 1;
        break;
      end
      if (DumpValid && idx == abort) return;
      if (noisy) begin
        Finish = 1'($urandom_range(0, 1));
        NegCycle = 1'($urandom_range(0, 1));
      end
      DumpReady = always_rdy ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      if (DumpValid && DumpReady) begin
        chk("word", 32'(DumpData), 32'(mem[idx]));
        chk("inf", 32'(DumpInf), 32'(mem[idx] == 16'hFFFF));
        chk("last", 32'(DumpLast), 32'(idx == DEPTH - 1));
        if (always_rdy) chk("rate", 32'(cyc), 32'(2 + 2 * idx));
        idx++;
      end
      hold = DumpValid && !DumpReady;
      hold_data = DumpData;
    end
    if (!fin) chk("dump_timeout", 32'(idx), 32'(DEPTH + 1));
  endtask
  initial begin
    reset = 1; Finish = 1; NegCycle = 1; DumpReady = 0;
    mem[0] = 16'd5; mem[1] = 16'hFFFF; mem[2] = 16'd0; mem[3] = 16'd12;
    repeat (2) @(negedge clock);
    chk_idle_zero("reset");
    reset = 0;
    repeat (3) @(negedge clock);
    chk_idle_zero("held_flags");
    run_dump(1, 0, -1);
    for (int i = 0; i < 8; i++) begin
      Finish = 1'(i & 1); NegCycle = 1'((i >> 1) & 1);
      DumpReady = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("after_done_done", 32'(Done), 1);
      chk("after_done_neg", 32'(NegFlag), 0);
      chk("after_done_valid", 32'(DumpValid), 0);
      chk("after_done_omar", 32'(OMAR), DEPTH - 1);
      chk("after_done_busy", 32'(Busy), 0);
    end
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < DEPTH; k++) mem[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      do_reset();
      run_dump(0, 1, -1);
    end
    do_reset();
    run_dump(0, 0, 2);
    Finish = 1;
    reset = 1;
    @(negedge clock);
    chk_idle_zero("mid_reset");
    reset = 0;
    repeat (3) @(negedge clock);
    chk_idle_zero("mid_reset_hold");
    run_dump(1, 0, -1);
    do_reset();
    Finish = 0; NegCycle = 0;
    @(negedge clock);
    Finish = 1; NegCycle = 1;
    for (int i = 0; i < 8; i++) begin
      DumpReady = 1'($urandom_range(0, 1));
      if (i > 2) begin Finish = 1'(i & 1); NegCycle = 1'(~i & 1); end
      @(negedge clock);
      chk("neg_flag", 32'(NegFlag), 1);
      chk("neg_done", 32'(Done), 1);
      chk("neg_valid", 32'(DumpValid), 0);
      chk("neg_omar", 32'(OMAR), 0);
      chk("neg_busy", 32'(Busy), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
